// File: rtl/spi_frame_receiver.sv
// spi_frame_receiver
// Synchronises raw SPI pins (nCS, SCLK, COPI) into the clk domain and
// shifts in fixed-length mode-0 frames: R/W bit, ADDR_W address bits,
// DATA_W data bits, MSB first.
// A completed write frame produces a one-cycle wr_valid strobe with
// address and data. A short or overrun frame produces a one-cycle
// frame_err pulse.
// Optional feature: define SPI_FRAME_RX_READBACK_EN to add the rd_addr,
// rd_data and cipo_out readback path for read frames.
// SYNC_STAGES is meant to be 2 or 3. SCLK high and low phases must each
// last at least SYNC_STAGES+1 clk periods.
module spi_frame_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ncs_in,
  input  logic              sclk_in,
  input  logic              copi_in,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              frame_err,
`ifdef SPI_FRAME_RX_READBACK_EN
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              cipo_out,
`endif
  output logic              busy
);

  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 2);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    SHIFT
  } state_t;

  state_t state;
  state_t next_state;

  logic [SYNC_STAGES-1:0] ncs_sync;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] copi_sync;
  logic                   ncs_hist;
  logic                   sclk_hist;

  logic ncs_s;
  logic sclk_s;
  logic copi_s;
  logic ncs_fall;
  logic ncs_rise;
  logic sclk_rise;

  logic [FRAME_W-1:0] shift_reg;
  logic [CNT_W-1:0]   bit_cnt;

  logic cnt_clear;
  logic shift_en;
  logic commit_wr;
  logic commit_err;

  // Pin synchronisers plus one history flop each for nCS and SCLK edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ncs_sync  <= '1;
      sclk_sync <= '0;
      copi_sync <= '0;
      ncs_hist  <= 1'b1;
      sclk_hist <= 1'b0;
    end else begin
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs_in};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi_in};
      ncs_hist  <= ncs_sync[SYNC_STAGES-1];
      sclk_hist <= sclk_sync[SYNC_STAGES-1];
    end
  end

  assign ncs_s     = ncs_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign copi_s    = copi_sync[SYNC_STAGES-1];
  assign ncs_fall  = ncs_hist & ~ncs_s;
  assign ncs_rise  = ~ncs_hist & ncs_s;
  assign sclk_rise = ~sclk_hist & sclk_s;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= WAIT_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and control decode; an nCS rise takes priority over a coincident SCLK rise
  always_comb begin
    next_state = state;
    cnt_clear  = 1'b0;
    shift_en   = 1'b0;
    commit_wr  = 1'b0;
    commit_err = 1'b0;
    case (state)
      WAIT_IDLE: begin
        if (ncs_s) begin
          next_state = IDLE;
        end
      end
      IDLE: begin
        if (ncs_fall) begin
          next_state = SHIFT;
          cnt_clear  = 1'b1;
        end
      end
      SHIFT: begin
        if (ncs_rise) begin
          next_state = IDLE;
          if (bit_cnt == CNT_FULL) begin
            commit_wr = shift_reg[FRAME_W-1];
          end else if (bit_cnt != '0) begin
            commit_err = 1'b1;
          end
        end else if (sclk_rise && !ncs_s) begin
          shift_en = 1'b1;
        end
      end
      default: begin
        next_state = WAIT_IDLE;
      end
    endcase
  end

  // Frame shift register and saturating bit counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (cnt_clear) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (shift_en) begin
      shift_reg <= {shift_reg[FRAME_W-2:0], copi_s};
      if (bit_cnt != CNT_SAT) begin
        bit_cnt <= bit_cnt + CNT_ONE;
      end
    end
  end

  // Commit strobes; address and data hold their last committed value between writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_valid  <= 1'b0;
      frame_err <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      wr_valid  <= commit_wr;
      frame_err <= commit_err;
      if (commit_wr) begin
        wr_addr <= shift_reg[FRAME_W-2 -: ADDR_W];
        wr_data <= shift_reg[DATA_W-1:0];
      end
    end
  end

  assign busy = (state == SHIFT);

`ifdef SPI_FRAME_RX_READBACK_EN
  localparam logic [CNT_W-1:0] CNT_ADDR_LAST = CNT_W'(ADDR_W);

  logic              sclk_fall;
  logic              addr_done_read;
  logic              rd_capture;
  logic              rd_phase;
  logic [DATA_W-1:0] rd_shift;

  assign sclk_fall = sclk_hist & ~sclk_s;

  // The shift that completes the address field of a read frame. Before this
  // shift, the R/W bit sits at position ADDR_W-1.
  assign addr_done_read = shift_en && (bit_cnt == CNT_ADDR_LAST) && !shift_reg[ADDR_W-1];

  // Present the read address, capture rd_data one clk later, then serialise it on SCLK falls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr    <= '0;
      rd_capture <= 1'b0;
      rd_phase   <= 1'b0;
      rd_shift   <= '0;
      cipo_out   <= 1'b0;
    end else begin
      rd_capture <= addr_done_read;
      if (addr_done_read) begin
        rd_addr <= {shift_reg[ADDR_W-2:0], copi_s};
      end
      if (state != SHIFT) begin
        rd_phase <= 1'b0;
        cipo_out <= 1'b0;
      end else if (rd_capture) begin
        rd_shift <= rd_data;
        rd_phase <= 1'b1;
      end else if (rd_phase && sclk_fall) begin
        cipo_out <= rd_shift[DATA_W-1];
        rd_shift <= {rd_shift[DATA_W-2:0], 1'b0};
      end
    end
  end
`endif

endmodule

// File: tb/tb_spi_frame_receiver.sv
// tb_spi_frame_receiver
// Scoreboard bench for spi_frame_receiver. applyStimulus drives SPI frames
// and pushes the expected write/error events. A negedge monitor pops those
// events whenever the DUT strobes.
`timescale 1ns/1ps
module tb_spi_frame_receiver;

  localparam int SYNC    = 2;
  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 8;
  localparam int FRAME_W = 16;
  localparam int HALF    = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ncs_in = 1'b1;
  logic              sclk_in = 1'b0;
  logic              copi_in = 1'b0;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              frame_err;
  logic              busy;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t               exp_wr[$];
  int                exp_err = 0;
  int                errors = 0;
  int                checks = 0;
  bit                err_dont_care = 1'b0;
  logic [ADDR_W-1:0] last_addr = '0;
  logic [DATA_W-1:0] last_data = '0;

`ifdef SPI_FRAME_RX_READBACK_EN
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              cipo_out;
  logic [15:0]       cipo_cap;

  function automatic logic [DATA_W-1:0] rd_model(input logic [ADDR_W-1:0] a);
    return (a == 7'h02) ? 8'h96 : 8'h5A;
  endfunction

  assign rd_data = rd_model(rd_addr);
`endif

  spi_frame_receiver #(
    .SYNC_STAGES(SYNC),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ncs_in(ncs_in),
    .sclk_in(sclk_in),
    .copi_in(copi_in),
    .wr_valid(wr_valid),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .frame_err(frame_err),
`ifdef SPI_FRAME_RX_READBACK_EN
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .cipo_out(cipo_out),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: pops expected events whenever the DUT strobes
  always @(negedge clk) begin : monitor
    wr_t e;
    if (!rst) begin
      if (wr_valid) begin
        if (exp_wr.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_wr_valid: actual=1 required=0 (addr=0x%0h data=0x%0h)", wr_addr, wr_data);
        end else begin
          e = exp_wr.pop_front();
          checkOutput("wr_addr", 32'(wr_addr), 32'(e.addr));
          checkOutput("wr_data", 32'(wr_data), 32'(e.data));
        end
      end
      if (frame_err && !err_dont_care) begin
        checks++;
        if (exp_err == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_frame_err: actual=1 required=0");
        end else begin
          exp_err--;
        end
      end
    end
  end

  // Clock nbits bits MSB first with SCLK phases of HALF clk periods
  task automatic sendBits(input logic [31:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      copi_in = bits[nbits-1-i];
      repeat (HALF) @(negedge clk);
`ifdef SPI_FRAME_RX_READBACK_EN
      if (i < 16) cipo_cap[15-i] = cipo_out;
`endif
      sclk_in = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk_in = 1'b0;
    end
  endtask

  // One full frame. The reference model predicts the commit outcome from the bit count and the R/W bit.
  task automatic applyStimulus(input logic [31:0] bits, input int nbits);
    bit         expect_evt;
    wr_t        w;
    logic [7:0] obs;
    logic [7:0] exp_obs;
    expect_evt = 1'b0;
    if (nbits == FRAME_W) begin
      if (bits[15]) begin
        w.addr = bits[14:8];
        w.data = bits[7:0];
        exp_wr.push_back(w);
        last_addr = w.addr;
        last_data = w.data;
        expect_evt = 1'b1;
      end
    end else if (nbits != 0) begin
      exp_err++;
      expect_evt = 1'b1;
    end
`ifdef SPI_FRAME_RX_READBACK_EN
    cipo_cap = '0;
`endif
    @(negedge clk);
    ncs_in = 1'b0;
    repeat (HALF) @(negedge clk);
    checkOutput("busy_in_frame", 32'(busy), 32'd1);
    sendBits(bits, nbits);
    repeat (HALF) @(negedge clk);
    ncs_in = 1'b1;
    obs = '0;
    for (int k = 1; k <= SYNC + 2; k++) begin
      @(negedge clk);
      obs[k] = wr_valid | frame_err;
    end
    exp_obs = expect_evt ? 8'(1 << (SYNC + 1)) : 8'h00;
    checkOutput("strobe_timing", 32'(obs), 32'(exp_obs));
    repeat (HALF) @(negedge clk);
    checkOutput("busy_after_frame", 32'(busy), 32'd0);
    checkOutput("hold_addr", 32'(wr_addr), 32'(last_addr));
    checkOutput("hold_data", 32'(wr_data), 32'(last_data));
`ifdef SPI_FRAME_RX_READBACK_EN
    if (nbits == FRAME_W && !bits[15]) begin
      checkOutput("rd_addr", 32'(rd_addr), 32'(bits[14:8]));
      checkOutput("cipo_bits", 32'(cipo_cap), {16'h0, 8'h00, rd_model(bits[14:8])});
    end
`endif
  endtask

  initial begin
    int nb;
    $display("[TB] start");
    repeat (3) @(negedge clk);
    checkOutput("reset_wr_valid", 32'(wr_valid), 32'd0);
    checkOutput("reset_frame_err", 32'(frame_err), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_wr_addr", 32'(wr_addr), 32'd0);
    checkOutput("reset_wr_data", 32'(wr_data), 32'd0);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    $display("[TB] directed write and read frames");
    applyStimulus(32'h84A5, 16);
    applyStimulus(32'h0400, 16);

    $display("[TB] short and overrun frames");
    applyStimulus(32'h2A5, 10);
    applyStimulus(32'h1ABCD, 17);

    $display("[TB] reset in mid-frame");
    @(negedge clk);
    ncs_in = 1'b0;
    repeat (HALF) @(negedge clk);
    sendBits(32'h15, 5);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_wr_addr", 32'(wr_addr), 32'd0);
    checkOutput("midreset_wr_data", 32'(wr_data), 32'd0);
    last_addr = '0;
    last_data = '0;
    err_dont_care = 1'b1;
    rst = 1'b0;
    sendBits(32'h5A3, 11);
    repeat (HALF) @(negedge clk);
    ncs_in = 1'b1;
    repeat (SYNC + 6) @(negedge clk);
    err_dont_care = 1'b0;
    checkOutput("post_reset_no_write", 32'(wr_addr), 32'd0);
    applyStimulus(32'h813C, 16);

    $display("[TB] empty nCS pulse and SCLK while deselected");
    applyStimulus(32'h0, 0);
    for (int i = 0; i < 6; i++) begin
      copi_in = 1'($urandom);
      sclk_in = 1'b1;
      repeat (HALF) @(negedge clk);
      checkOutput("busy_idle_sclk", 32'(busy), 32'd0);
      sclk_in = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    checkOutput("idle_hold_addr", 32'(wr_addr), 32'(last_addr));

`ifdef SPI_FRAME_RX_READBACK_EN
    $display("[TB] readback of address 0x02");
    applyStimulus(32'h0200, 16);
`endif

    $display("[TB] randomized frames");
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 9) < 6) nb = FRAME_W;
      else nb = $urandom_range(0, 20);
      applyStimulus($urandom, nb);
    end

    repeat (20) @(negedge clk);
    checkOutput("pending_writes", 32'(exp_wr.size()), 32'd0);
    checkOutput("pending_errors", 32'(exp_err), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
